fan_ramp_sequencer: RTL and testbench

//  Sequencer in front of PWM_controller: generates its clk_en, and drives its duty/min/period inputs.

---
 rtl/fan_ctrl_pkg.sv | 17 +
 rtl/clk_en_prescaler.sv | 35 +++
 rtl/fan_ramp_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fan_ramp_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan ramp sequencer: FSM state encoding
// and the kick-start duty value.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_t;

    localparam int unsigned RAMP_DIV_W = 4;

    // Full-duty kick value; the top slices it down to its counter width.
    localparam logic [31:0] KICK_DUTY_ALL = '1;

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable prescaler: produces a one-cycle registered pulse every
// prescale_i+1 clocks; prescale_i=0 yields a constant enable after reset.
module clk_en_prescaler #(
    parameter int unsigned PRESCALER_BITWIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [PRESCALER_BITWIDTH-1:0] prescale_i,
    output logic                          clk_en_o
);

    logic [PRESCALER_BITWIDTH-1:0] pcnt_q, pcnt_d;
    logic                          clk_en_q, clk_en_d;
    logic                          wrap;

    // >= keeps the counter bounded if prescale_i is lowered mid-count.
    always_comb begin
        wrap     = (pcnt_q >= prescale_i);
        pcnt_d   = wrap ? '0 : pcnt_q + 1'b1;
        clk_en_d = wrap;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pcnt_q   <= '0;
            clk_en_q <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule

// File: rtl/fan_ramp_sequencer.sv
// Fan start-up sequencer feeding a PWM controller: full-duty kick-start, then
// a one-LSB-per-interval duty ramp toward target_i in either direction.
module fan_ramp_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned COUNTER_BITWIDTH   = 5,
    parameter int unsigned PRESCALER_BITWIDTH = 8,
    parameter int unsigned KICK_PERIODS       = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          enable_i,
    input  logic [COUNTER_BITWIDTH-1:0]   target_i,
    input  logic [COUNTER_BITWIDTH-1:0]   min_i,
    input  logic [COUNTER_BITWIDTH:0]     period_i,
    input  logic [PRESCALER_BITWIDTH-1:0] prescale_i,
    input  logic [RAMP_DIV_W-1:0]         ramp_div_i,
    output logic                          clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]   counterValue_o,
    output logic [COUNTER_BITWIDTH-1:0]   minCounterValue_o,
    output logic [COUNTER_BITWIDTH:0]     periodCounterValue_o,
    output logic [1:0]                    state_o,
    output logic                          at_target_o
);

    localparam int unsigned CB = COUNTER_BITWIDTH;
    localparam int unsigned KW = $clog2(KICK_PERIODS + 2);
    localparam logic [KW-1:0] KICK_LAST = (KICK_PERIODS == 0) ? '0 : KW'(KICK_PERIODS - 1);
    localparam logic [CB-1:0] KICK_DUTY = KICK_DUTY_ALL[CB-1:0];

    logic                  clk_en;
    logic                  per_tick, ramp_tick;
    logic [CB:0]           per_cnt_q, per_cnt_d;
    logic [CB:0]           per_reg_q, per_reg_d;
    logic [RAMP_DIV_W-1:0] rcnt_q, rcnt_d;
    logic [KW-1:0]         kcnt_q, kcnt_d;
    fan_state_t            state_q, state_d;
    logic [CB-1:0]         cur_q, cur_d;
    logic [CB-1:0]         duty_q, duty_d;
    logic [CB-1:0]         minv_q, minv_d;

    clk_en_prescaler #(
        .PRESCALER_BITWIDTH(PRESCALER_BITWIDTH)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .prescale_i (prescale_i),
        .clk_en_o   (clk_en)
    );

    // Period mirror tracks the PWM controller's period so ramp/kick timing
    // is expressed in PWM periods; period_i is only latched at a period boundary.
    always_comb begin
        per_tick  = clk_en && (per_cnt_q == per_reg_q);
        ramp_tick = per_tick && (rcnt_q >= ramp_div_i);
        per_cnt_d = per_cnt_q;
        per_reg_d = per_reg_q;
        if (per_tick) begin
            per_cnt_d = '0;
            per_reg_d = period_i;
        end else if (clk_en) begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        kcnt_d  = kcnt_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cur_d   = '0;
            kcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cur_d  = '0;
                    kcnt_d = '0;
                    if (target_i != '0) begin
                        state_d = (KICK_PERIODS == 0) ? ST_RAMP : ST_KICK;
                    end
                end
                ST_KICK: begin
                    if (per_tick) begin
                        if (kcnt_q == KICK_LAST) begin
                            state_d = ST_RAMP;
                            kcnt_d  = '0;
                        end else begin
                            kcnt_d = kcnt_q + 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    // Reaching the target takes priority over a coincident step.
                    if (cur_q == target_i) begin
                        state_d = (target_i == '0) ? ST_IDLE : ST_HOLD;
                    end else if (ramp_tick) begin
                        if (cur_q < target_i && cur_q != '1) begin
                            cur_d = cur_q + 1'b1;
                        end else if (cur_q > target_i && cur_q != '0) begin
                            cur_d = cur_q - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (target_i != cur_q) begin
                        state_d = ST_RAMP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                    kcnt_d  = '0;
                end
            endcase
        end

        case (state_d)
            ST_IDLE: begin
                duty_d = '0;
                minv_d = '0;
            end
            ST_KICK: begin
                duty_d = KICK_DUTY;
                minv_d = min_i;
            end
            default: begin
                duty_d = cur_d;
                minv_d = min_i;
            end
        endcase
    end

    always_comb begin
        rcnt_d = rcnt_q;
        if (state_d != state_q || ramp_tick) begin
            rcnt_d = '0;
        end else if (per_tick) begin
            rcnt_d = rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            per_cnt_q <= '0;
            per_reg_q <= '0;
            rcnt_q    <= '0;
            kcnt_q    <= '0;
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            duty_q    <= '0;
            minv_q    <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            per_reg_q <= per_reg_d;
            rcnt_q    <= rcnt_d;
            kcnt_q    <= kcnt_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            duty_q    <= duty_d;
            minv_q    <= minv_d;
        end
    end

    assign clk_en_o             = clk_en;
    assign counterValue_o       = duty_q;
    assign minCounterValue_o    = minv_q;
    assign periodCounterValue_o = per_reg_q;
    assign state_o              = state_q;
    assign at_target_o          = (state_q == ST_HOLD);

endmodule

// File: tb/tb_fan_ramp_sequencer.sv
// Bench for fan_ramp_sequencer: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fan_ramp_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable;
    logic [4:0] target;
    logic [4:0] min_v;
    logic [5:0] period;
    logic [7:0] prescale;
    logic [3:0] ramp_div;
    logic       clk_en_o;
    logic [4:0] counterValue_o;
    logic [4:0] minCounterValue_o;
    logic [5:0] periodCounterValue_o;
    logic [1:0] state_o;
    logic       at_target_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    fan_ramp_sequencer #(
        .COUNTER_BITWIDTH   (5),
        .PRESCALER_BITWIDTH (8),
        .KICK_PERIODS       (4)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .enable_i             (enable),
        .target_i             (target),
        .min_i                (min_v),
        .period_i             (period),
        .prescale_i           (prescale),
        .ramp_div_i           (ramp_div),
        .clk_en_o             (clk_en_o),
        .counterValue_o       (counterValue_o),
        .minCounterValue_o    (minCounterValue_o),
        .periodCounterValue_o (periodCounterValue_o),
        .state_o              (state_o),
        .at_target_o          (at_target_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Behavioural model. Time is tracked as "clocks since last enable pulse",
    // "enable pulses into the current PWM period" and "periods since the last
    // duty step"; the phase is an integer 0=idle 1=kick 2=ramp 3=hold.
    int  m_since, m_en, m_pulses, m_plen, m_steps, m_kicks;
    int  m_phase, m_cur, m_min;
    bit  model_ok = 0;

    function automatic int duty_of(input int phase, input int cur);
        if (phase == 0) return 0;
        if (phase == 1) return 31;
        return cur;
    endfunction

    initial forever begin
        int boundary, step, nphase, ncur;
        @(posedge clk);
        ncyc = ncyc + 1;
        if (!rstn) begin
            m_since = 0; m_en = 0; m_pulses = 0; m_plen = 0; m_steps = 0;
            m_kicks = 0; m_phase = 0; m_cur = 0; m_min = 0;
            model_ok = 1;
        end else begin
            boundary = (m_en == 1) && (m_pulses == m_plen);
            step     = boundary && (m_steps >= int'(ramp_div));
            nphase   = m_phase;
            ncur     = m_cur;
            if (!enable) begin
                nphase = 0; ncur = 0; m_kicks = 0;
            end else if (m_phase == 0) begin
                ncur = 0; m_kicks = 0;
                if (target != 0) nphase = 1;
            end else if (m_phase == 1) begin
                if (boundary) begin
                    m_kicks = m_kicks + 1;
                    if (m_kicks == 4) begin nphase = 2; m_kicks = 0; end
                end
            end else if (m_phase == 2) begin
                if (m_cur == int'(target)) nphase = (target == 0) ? 0 : 3;
                else if (step) ncur = m_cur + ((int'(target) > m_cur) ? 1 : -1);
            end else begin
                if (m_cur != int'(target)) nphase = 2;
            end
            if (nphase != m_phase || step) m_steps = 0;
            else if (boundary) m_steps = m_steps + 1;
            if (boundary) begin m_pulses = 0; m_plen = int'(period); end
            else if (m_en == 1) m_pulses = m_pulses + 1;
            if (m_since >= int'(prescale)) begin m_en = 1; m_since = 0; end
            else begin m_en = 0; m_since = m_since + 1; end
            m_phase = nphase;
            m_cur   = ncur;
            m_min   = (nphase != 0) ? int'(min_v) : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("cyc_clk_en",  int'(clk_en_o), m_en);
            chk("cyc_duty",    int'(counterValue_o), duty_of(m_phase, m_cur));
            chk("cyc_min",     int'(minCounterValue_o), m_min);
            chk("cyc_period",  int'(periodCounterValue_o), m_plen);
            chk("cyc_state",   int'(state_o), m_phase);
            chk("cyc_at_tgt",  int'(at_target_o), (m_phase == 3) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int left = budget;
        while (int'(state_o) != st && left > 0) begin
            @(negedge clk);
            left = left - 1;
        end
        chk(name, int'(state_o), st);
    endtask

    int seen[8];
    int nseen;

    task automatic ramp_track(input int start, input int stop, input int budget);
        int last = start;
        bit ramped = 0;
        nseen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state_o == 2'd2) begin
                ramped = 1;
                if (int'(counterValue_o) != last && nseen < 8) begin
                    seen[nseen] = int'(counterValue_o);
                    nseen = nseen + 1;
                    last = int'(counterValue_o);
                end
            end else if (ramped && int'(state_o) == stop) begin
                break;
            end
        end
        chk("ramp_end_state", int'(state_o), stop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, run, maxrun, t_prev, t_now, left;
        rstn = 1'b0; enable = 1'b0; target = '0; min_v = '0;
        period = 6'd9; prescale = 8'd3; ramp_div = 4'd0;

        cyc(2);
        chk("rst_duty",   int'(counterValue_o), 0);
        chk("rst_min",    int'(minCounterValue_o), 0);
        chk("rst_period", int'(periodCounterValue_o), 0);
        chk("rst_state",  int'(state_o), 0);
        chk("rst_clk_en", int'(clk_en_o), 0);
        rstn = 1'b1;

        // Prescaler: divide-by-4 pulses, then constant enable.
        ones = 0; run = 0; maxrun = 0;
        repeat (40) begin
            @(negedge clk);
            if (clk_en_o) begin
                ones = ones + 1; run = run + 1;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        chk("pre3_pulses", ones, 10);
        chk("pre3_width", maxrun, 1);
        prescale = 8'd0;
        cyc(2);
        ones = 0;
        repeat (20) begin
            @(negedge clk);
            if (clk_en_o) ones = ones + 1;
        end
        chk("pre0_const", ones, 20);

        // Start-up: kick then ramp up to 5.
        min_v = 5'd2; target = 5'd5; enable = 1'b1;
        wait_state(1, 5, "t2_kick_entry");
        chk("t2_kick_duty", int'(counterValue_o), 31);
        chk("t2_kick_min",  int'(minCounterValue_o), 2);
        ramp_track(0, 3, 300);
        chk("t2_nsteps", nseen, 5);
        for (int i = 0; i < 5; i++) chk("t2_step_val", seen[i], i + 1);
        chk("t2_hold_duty", int'(counterValue_o), 5);
        chk("t2_at_target", int'(at_target_o), 1);
        chk("t2_period", int'(periodCounterValue_o), 9);

        // Ramp down to 2, then to 0 which ends in IDLE.
        target = 5'd2;
        ramp_track(5, 3, 300);
        chk("t3_nsteps", nseen, 3);
        for (int i = 0; i < 3; i++) chk("t3_step_val", seen[i], 4 - i);
        target = 5'd0;
        ramp_track(2, 0, 300);
        chk("t3_nsteps0", nseen, 2);
        chk("t3_last0", seen[1], 0);
        chk("t3_idle_duty", int'(counterValue_o), 0);
        chk("t3_idle_min",  int'(minCounterValue_o), 0);

        // Disable mid-ramp at cur=3, then re-enable.
        target = 5'd5;
        left = 400;
        while (!(state_o == 2'd2 && counterValue_o == 5'd3) && left > 0) begin
            @(negedge clk);
            left = left - 1;
        end
        chk("t4_reach_cur3", int'(counterValue_o), 3);
        enable = 1'b0;
        cyc(1);
        chk("t4_off_state", int'(state_o), 0);
        chk("t4_off_duty",  int'(counterValue_o), 0);
        chk("t4_off_min",   int'(minCounterValue_o), 0);
        enable = 1'b1;
        cyc(1);
        chk("t4_rekick_state", int'(state_o), 1);
        chk("t4_rekick_duty",  int'(counterValue_o), 31);

        // One-cycle reset during KICK.
        cyc(3);
        rstn = 1'b0;
        cyc(1);
        chk("t5_state",  int'(state_o), 0);
        chk("t5_duty",   int'(counterValue_o), 0);
        chk("t5_min",    int'(minCounterValue_o), 0);
        chk("t5_period", int'(periodCounterValue_o), 0);
        chk("t5_clk_en", int'(clk_en_o), 0);
        rstn = 1'b1;
        cyc(4);

        // Period latch timing, then ramp_div=2 step spacing.
        rstn = 1'b0; target = 5'd0;
        cyc(1);
        rstn = 1'b1; period = 6'd9; prescale = 8'd0; ramp_div = 4'd0;
        cyc(5);
        chk("t6_per_before", int'(periodCounterValue_o), 9);
        period = 6'd4;
        cyc(6);
        chk("t6_per_held", int'(periodCounterValue_o), 9);
        cyc(1);
        chk("t6_per_update", int'(periodCounterValue_o), 4);
        ramp_div = 4'd2; target = 5'd3;
        wait_state(2, 200, "t6_ramp_entry");
        t_prev = ncyc;
        for (int k = 1; k <= 3; k++) begin
            left = 100;
            while (int'(counterValue_o) != k && left > 0) begin
                @(negedge clk);
                left = left - 1;
            end
            t_now = ncyc;
            chk("t6_step_gap", t_now - t_prev, 15);
            t_prev = t_now;
        end
        wait_state(3, 10, "t6_hold");
        chk("t6_hold_duty", int'(counterValue_o), 3);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
